viterbi_out_packer: RTL and testbench
=====================================

Name: viterbi_out_packer

Overview:
- Parametrised output packer for the Viterbi decoder back end.
- Collects SIZE_IN-bit decoded chunks from the traceback unit and packs them into SIZE_OUT-bit words.
- Presents the words on a registered valid/ready interface to the system bus.
- Adds backpressure, early flush of a partial word on end-of-frame, a fill count and synchronous clear. The previous output stage had none of these.

Parameters:
- SIZE_IN, 1, width of one decoded chunk in bits.
- SIZE_OUT, 8, output word width in bits. Must be an integer multiple of SIZE_IN, checked by elaboration assertion.
- N (localparam), SIZE_OUT/SIZE_IN, chunks per word.
- CNT_W (localparam), $clog2(N+1), width of the fill counter and o_count.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_clear  in  1  synchronous clear: drops the partial word and the pending output word.
- i_valid  in  1  input chunk valid.
- i_data  in  SIZE_IN  decoded chunk.
- i_last  in  1  chunk is the last of the frame; flush after it.
- o_ready  out  1  packer can accept a chunk this cycle.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the word.
- o_data  out  SIZE_OUT  packed word.
- o_count  out  CNT_W  number of valid chunks in o_data (1..N).
- o_last  out  1  word closes a frame.

Behaviour:
- Reset: o_valid=0, o_data=0, o_count=0, o_last=0. Accumulator, fill counter and state all cleared. o_ready=1 after reset.
- State machine:
  - FILL: counter 0..N-1, accumulating.
  - HOLD: output register occupied, waiting for i_ready.
  - The output register is a single stage, so both phases can be live simultaneously. The state tracks the accumulator only.
- Output register:
  - o_valid is registered.
  - A word becomes visible the cycle after its completing chunk is accepted (latency 1).
- Output handshake:
  - Transfer occurs when o_valid && i_ready.
  - o_data, o_count and o_last are held stable while o_valid && !i_ready.
- Input handshake:
  - o_ready = !o_valid || i_ready (combinational).
  - A chunk is accepted when i_valid && o_ready.
  - With o_ready=0 the chunk is not consumed, and the source holds i_data, i_valid and i_last.
- Packing:
  - The first accepted chunk of a word lands in bits [SIZE_OUT-1 -: SIZE_IN].
  - Each subsequent chunk goes to the next lower slot.
- Word completion:
  - A word completes when the accepted chunk brings the counter to N, or when it carries i_last.
  - On completion the word moves to the output register. o_count = chunks in the word; o_last = i_last of that chunk.
  - The accumulator and counter reset in the same cycle, so the next chunk can be accepted the following cycle without a bubble.
- Partial flush: unused low slots are zero-filled. Example: 3 chunks of 1 bit with values 1,1,0 give o_data=0xC0 and o_count=3.
- Simultaneous events:
  - Output drain and completion of a new word in the same cycle: the new word is loaded and o_valid stays 1.
  - i_valid with o_ready=0: no accept.
- i_clear has priority over everything: o_valid=0, the accumulator empties, counter=0. A chunk presented in that cycle is discarded, even if accepted.
- Reset mid-operation: everything is discarded immediately, with no partial word output.
- Counter wrap: the counter never exceeds N. Reaching N always completes the word.

Optional Feature:
- Macro: VITERBI_OUT_PACKER_LSB_FIRST_EN.
- Defined: the first chunk lands in bits [SIZE_IN-1:0] and subsequent chunks fill upward. Partial words are zero-filled in the high slots.
- Undefined: MSB-first packing as in Behaviour.
- All other timing is identical.

Decomposition:
- Package viterbi_out_pkg holds:
  - the state enum (S_FILL, S_HOLD);
  - a function computing CNT_W;
  - the shared packing-order constant.
- One sub-module, viterbi_out_reg_stage: a single-entry valid/ready output register carrying data, count and last. The packer instantiates it.

Test Plan (SIZE_IN=1, SIZE_OUT=8 unless stated):
- Full word: bits 1,0,1,1,0,0,1,0 with i_ready=1 -> o_valid one cycle after the 8th accept, o_data=0xB2, o_count=8, o_last=0.
- Partial flush: bits 1,1,0, i_last on the third -> o_data=0xC0, o_count=3, o_last=1. Next word starts from count 0.
- Backpressure: complete a word with i_ready=0 -> o_ready=0 and the output is held stable for 5 cycles. Raise i_ready -> transfer, and o_ready=1 in the same cycle.
- Back-to-back: 16 bits streaming continuously with i_ready=1 -> two words, no input stall, o_valid high on consecutive transfers.
- SIZE_IN=2: chunks 11,00,10,01 -> o_data=0xC9. With VITERBI_OUT_PACKER_LSB_FIRST_EN -> o_data=0x63.
- Clear and reset: i_clear after 4 bits -> no output, o_count=0, and a fresh 8 bits give a correct word. Repeat with i_rst_n pulsed mid-word -> all outputs 0.

Source files
------------

// File: rtl/viterbi_out_pkg.sv
// Shared types and constants for the Viterbi decoder output packer.
// Optional build macro: VITERBI_OUT_PACKER_LSB_FIRST_EN selects LSB-first slot order.
package viterbi_out_pkg;

  // Accumulator phase: filling slots, or stalled behind an occupied output register.
  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  // Width needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

`ifdef VITERBI_OUT_PACKER_LSB_FIRST_EN
  localparam bit PACK_MSB_FIRST = 1'b0;
`else
  localparam bit PACK_MSB_FIRST = 1'b1;
`endif

endpackage

// File: rtl/viterbi_out_reg_stage.sv
// Single-entry valid/ready output register carrying packed data, chunk count and
// end-of-frame flag. Contents are held stable while valid is stalled by the sink.
module viterbi_out_reg_stage #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_last
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q;
  logic              last_q;

  // Load a new word (possibly while draining the old one), drop valid on transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (i_clear) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (i_load) begin
      valid_q <= 1'b1;
      data_q  <= i_data;
      count_q <= i_count;
      last_q  <= i_last;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_count = count_q;
  assign o_last  = last_q;

endmodule

// File: rtl/viterbi_out_packer.sv
// Packs SIZE_IN-bit traceback chunks into SIZE_OUT-bit words with backpressure,
// end-of-frame flush and synchronous clear.
// Optional build macro: VITERBI_OUT_PACKER_LSB_FIRST_EN (first chunk in the low slot).
module viterbi_out_packer
  import viterbi_out_pkg::*;
#(
  parameter int  SIZE_IN  = 1,
  parameter int  SIZE_OUT = 8,
  localparam int N        = SIZE_OUT / SIZE_IN,
  localparam int CNT_W    = cnt_width(N)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic [SIZE_IN-1:0]  i_data,
  input  logic                i_last,
  output logic                o_ready,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_OUT-1:0] o_data,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_last
);

  if ((SIZE_IN < 1) || ((SIZE_OUT % SIZE_IN) != 0)) begin : g_bad_size
    $error("viterbi_out_packer: SIZE_OUT must be a positive multiple of SIZE_IN");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SIZE_OUT-1:0] acc_q, acc_d;
  logic [SIZE_OUT-1:0] word_merged;
  logic [CNT_W-1:0]    cnt_inc;
  logic                take;
  logic                complete;

  // Drop the incoming chunk into the slot selected by the fill counter; slots not
  // yet written are still zero, which gives the zero fill on a partial flush.
  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    localparam int LO = PACK_MSB_FIRST ? (SIZE_OUT - (gi + 1) * SIZE_IN) : (gi * SIZE_IN);
    assign word_merged[LO +: SIZE_IN] = (cnt_q == CNT_W'(gi)) ? i_data : acc_q[LO +: SIZE_IN];
  end

  assign o_ready  = (state_q == S_FILL) || i_ready;
  assign take     = i_valid && o_ready && !i_clear;
  assign cnt_inc  = cnt_q + 1'b1;
  assign complete = take && ((cnt_inc == CNT_W'(N)) || i_last);

  // Accumulator, fill counter and phase register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state: a completed word hands off to the output register and the
  // accumulator restarts empty in the same cycle, so there is no input bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (i_clear) begin
      state_d = S_FILL;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      if (complete) begin
        cnt_d = '0;
        acc_d = '0;
      end else if (take) begin
        cnt_d = cnt_inc;
        acc_d = word_merged;
      end
      unique case (state_q)
        S_FILL: if (complete) state_d = S_HOLD;
        S_HOLD: begin
          if (complete)     state_d = S_HOLD;
          else if (i_ready) state_d = S_FILL;
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  viterbi_out_reg_stage #(
    .DATA_W (SIZE_OUT),
    .CNT_W  (CNT_W)
  ) u_reg_stage (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_clear),
    .i_load  (complete),
    .i_data  (word_merged),
    .i_count (cnt_inc),
    .i_last  (i_last),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_count (o_count),
    .o_last  (o_last)
  );

endmodule

// File: tb/tb_viterbi_out_packer.sv
// Directed bench for viterbi_out_packer: SIZE_IN=1/SIZE_OUT=8 main instance plus
// a SIZE_IN=2 instance. Expected words depend on VITERBI_OUT_PACKER_LSB_FIRST_EN.
module tb_viterbi_out_packer;

`ifdef VITERBI_OUT_PACKER_LSB_FIRST_EN
  localparam logic [7:0] EXP_B2 = 8'h4D, EXP_C0 = 8'h03, EXP_80 = 8'h01, EXP_F0 = 8'h0F;
  localparam logic [7:0] EXP_5A = 8'h5A, EXP_08 = 8'h10, EXP_81 = 8'h81, EXP_C9 = 8'h63;
`else
  localparam logic [7:0] EXP_B2 = 8'hB2, EXP_C0 = 8'hC0, EXP_80 = 8'h80, EXP_F0 = 8'hF0;
  localparam logic [7:0] EXP_5A = 8'h5A, EXP_08 = 8'h08, EXP_81 = 8'h81, EXP_C9 = 8'hC9;
`endif

  logic       clk = 1'b0;
  logic       rst_n, clear, in_valid, in_data, in_last, out_ready_in;
  logic       o_ready, o_valid, o_last;
  logic [7:0] o_data;
  logic [3:0] o_count;

  logic       clear2, valid2, last2, ready2;
  logic [1:0] data2;
  logic       o_ready2, o_valid2, o_last2;
  logic [7:0] o_data2;
  logic [2:0] o_count2;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [7:0] held;

  always #5 clk = ~clk;

  viterbi_out_packer #(.SIZE_IN(1), .SIZE_OUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(in_valid),
    .i_data(in_data), .i_last(in_last), .o_ready(o_ready), .o_valid(o_valid),
    .i_ready(out_ready_in), .o_data(o_data), .o_count(o_count), .o_last(o_last)
  );

  viterbi_out_packer #(.SIZE_IN(2), .SIZE_OUT(8)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear2), .i_valid(valid2),
    .i_data(data2), .i_last(last2), .o_ready(o_ready2), .o_valid(o_valid2),
    .i_ready(ready2), .o_data(o_data2), .o_count(o_count2), .o_last(o_last2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s ok observed=0x%0h", tag, obs);
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send1(input logic d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (!o_ready) stalls++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("chunk %0d last=%0d -> o_valid=%0d o_data=0x%02h o_count=%0d", d, last, o_valid, o_data, o_count);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send1(b[i], 1'b0);
  endtask

  task automatic send2(input logic [1:0] d);
    valid2 = 1'b1;
    data2  = d;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
    $display("chunk2 %b -> o_valid=%0d o_data=0x%02h", d, o_valid2, o_data2);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_last = 1'b0;
    out_ready_in = 1'b1;
    clear2 = 1'b0; valid2 = 1'b0; data2 = 2'b00; last2 = 1'b0; ready2 = 1'b1;
    held = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_last",  32'(o_last),  32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    rst_n = 1'b1;
    idle();

    // Full word, latency 1 after the eighth accept.
    send1(1, 0); send1(0, 0); send1(1, 0); send1(1, 0);
    send1(0, 0); send1(0, 0); send1(1, 0);
    chk("full_pre_valid", 32'(o_valid), 32'd0);
    send1(0, 0);
    chk("full_valid", 32'(o_valid), 32'd1);
    chk("full_data",  32'(o_data),  32'(EXP_B2));
    chk("full_count", 32'(o_count), 32'd8);
    chk("full_last",  32'(o_last),  32'd0);
    idle();
    chk("full_drained", 32'(o_valid), 32'd0);

    // Partial flush on i_last.
    send1(1, 0); send1(1, 0); send1(0, 1);
    chk("part_valid", 32'(o_valid), 32'd1);
    chk("part_data",  32'(o_data),  32'(EXP_C0));
    chk("part_count", 32'(o_count), 32'd3);
    chk("part_last",  32'(o_last),  32'd1);

    // Drain and load in the same cycle; counter restarted from 0.
    send1(1, 1);
    chk("sim_valid", 32'(o_valid), 32'd1);
    chk("sim_data",  32'(o_data),  32'(EXP_80));
    chk("sim_count", 32'(o_count), 32'd1);
    send1(0, 1);
    chk("sim2_valid", 32'(o_valid), 32'd1);
    chk("sim2_data",  32'(o_data),  32'd0);
    chk("sim2_count", 32'(o_count), 32'd1);
    idle();

    // Backpressure: word held 5 cycles with a chunk waiting.
    out_ready_in = 1'b0;
    send_byte(8'hB2);
    chk("bp_valid", 32'(o_valid), 32'd1);
    held = o_data;
    chk("bp_data", 32'(held), 32'(EXP_B2));
    in_valid = 1'b1; in_data = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready_low", 32'(o_ready), 32'd0);
      chk("bp_hold_data", 32'(o_data),  32'(held));
      @(posedge clk);
      #1;
    end
    chk("bp_hold_valid", 32'(o_valid), 32'd1);
    out_ready_in = 1'b1;
    #1;
    chk("bp_ready_rise", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_transfer", 32'(o_valid), 32'd0);
    send1(0, 0); send1(0, 0); send1(0, 0); send1(0, 0);
    send1(0, 0); send1(0, 0); send1(1, 0);
    chk("bp_next_data",  32'(o_data),  32'(EXP_81));
    chk("bp_next_count", 32'(o_count), 32'd8);
    idle();

    // Back-to-back 16 bits.
    stalls = 0;
    send_byte(8'hF0);
    chk("b2b_w1_valid", 32'(o_valid), 32'd1);
    chk("b2b_w1_data",  32'(o_data),  32'(EXP_F0));
    send_byte(8'h5A);
    chk("b2b_w2_valid", 32'(o_valid), 32'd1);
    chk("b2b_w2_data",  32'(o_data),  32'(EXP_5A));
    chk("b2b_stalls",   32'(stalls),  32'd0);
    idle();

    // Clear after 4 bits, chunk in the clear cycle discarded.
    send1(1, 0); send1(1, 0); send1(1, 0); send1(1, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    idle();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_valid", 32'(o_valid), 32'd0);
    chk("clr_count", 32'(o_count), 32'd0);
    send_byte(8'hB2);
    chk("clr_fresh_data",  32'(o_data),  32'(EXP_B2));
    chk("clr_fresh_count", 32'(o_count), 32'd8);
    idle();
    out_ready_in = 1'b0;
    send_byte(8'hFF);
    chk("clrp_valid_pre", 32'(o_valid), 32'd1);
    clear = 1'b1;
    idle();
    clear = 1'b0;
    chk("clrp_valid", 32'(o_valid), 32'd0);
    chk("clrp_data",  32'(o_data),  32'd0);
    out_ready_in = 1'b1;
    idle();

    // Asynchronous reset with a pending word, then mid-word.
    out_ready_in = 1'b0;
    send_byte(8'hB2);
    chk("rstm_valid_pre", 32'(o_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_valid", 32'(o_valid), 32'd0);
    chk("rstm_data",  32'(o_data),  32'd0);
    chk("rstm_count", 32'(o_count), 32'd0);
    chk("rstm_last",  32'(o_last),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready_in = 1'b1;
    send1(1, 0); send1(1, 0); send1(1, 0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send1(0, 0); send1(0, 0); send1(0, 0); send1(0, 0); send1(1, 1);
    chk("rstw_data",  32'(o_data),  32'(EXP_08));
    chk("rstw_count", 32'(o_count), 32'd5);
    chk("rstw_last",  32'(o_last),  32'd1);
    idle();

    // SIZE_IN=2 instance.
    send2(2'b11); send2(2'b00); send2(2'b10);
    chk("w2_pre_valid", 32'(o_valid2), 32'd0);
    send2(2'b01);
    chk("w2_valid", 32'(o_valid2), 32'd1);
    chk("w2_data",  32'(o_data2),  32'(EXP_C9));
    chk("w2_count", 32'(o_count2), 32'd4);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
